// File: rtl/ahb_decode_mux.sv
// AHB-Lite decode/response-mux stage for the DES slave and the default slave.
// Decodes the address phase, tracks the selected slave through the data phase,
// muxes responses back and aborts stalled transfers with a watchdog ERROR.
module ahb_decode_mux #(
    parameter logic [31:0] DES_BASE = 32'h8000_0000,
    parameter logic [31:0] DES_MASK = 32'hFFFF_F000,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    output logic        HSEL_DES,
    output logic        HSEL_DEF,
    input  logic        HREADYOUT_DES,
    input  logic        HRESP_DES,
    input  logic [63:0] HRDATA_DES,
    input  logic        HREADYOUT_DEF,
    input  logic        HRESP_DEF,
    input  logic [63:0] HRDATA_DEF,
    output logic        HREADY,
    output logic        HRESP,
    output logic [63:0] HRDATA,
    output logic        TIMEOUT_ERR,
    output logic [7:0]  ERR_CNT
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ECNT_W = 8;

    typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_DES = 2'd1, SEL_DEF = 2'd2} dsel_t;
    typedef enum logic [1:0] {ST_NORM = 2'd0, ST_ERR1 = 2'd1, ST_ERR2 = 2'd2} state_t;

    dsel_t               r_dsel;
    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [ECNT_W-1:0]   r_err_cnt;

    logic                w_sel_des;
    logic                w_s_ready;
    logic                w_s_resp;
    logic [DATA_W-1:0]   w_s_rdata;
    logic                w_stall;
    logic                w_hready;
    logic                w_hresp;
    logic [DATA_W-1:0]   w_hrdata;
    logic                w_timeout_err;
    logic                w_unused;

    // HTRANS[0] only separates SEQ from NONSEQ and BUSY from IDLE; neither matters here.
    assign w_unused = HTRANS[0];

    // Address decode: zero latency, independent of HREADY and HTRANS.
    assign w_sel_des = ((HADDR & DES_MASK) == DES_BASE);
    assign HSEL_DES  = w_sel_des;
    assign HSEL_DEF  = ~w_sel_des;

    // Select the data-phase slave's response; no slave means zero-wait OKAY.
    always_comb begin
        w_s_ready = 1'b1;
        w_s_resp  = 1'b0;
        w_s_rdata = '0;
        case (r_dsel)
            SEL_DES: begin
                w_s_ready = HREADYOUT_DES;
                w_s_resp  = HRESP_DES;
                w_s_rdata = HRDATA_DES;
            end
            SEL_DEF: begin
                w_s_ready = HREADYOUT_DEF;
                w_s_resp  = HRESP_DEF;
                w_s_rdata = HRDATA_DEF;
            end
            default: ;
        endcase
    end

    // A slave signalling an error is not stalling, so its own error is never overridden.
    assign w_stall = (r_state == ST_NORM) && (r_dsel != SEL_NONE) && !w_s_ready && !w_s_resp;

    // Watchdog state register.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) r_state <= ST_NORM;
        else         r_state <= w_next;
    end

    // Watchdog next state: abort after TIMEOUT consecutive stall cycles.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_NORM: if (w_stall && (r_cnt == CNT_W'(TIMEOUT - 1))) w_next = ST_ERR1;
            ST_ERR1: w_next = ST_ERR2;
            ST_ERR2: w_next = ST_NORM;
            default: w_next = ST_NORM;
        endcase
    end

    // Response outputs: forward the slave in NORM, two-cycle ERROR during an abort.
    always_comb begin
        w_hready      = w_s_ready;
        w_hresp       = w_s_resp;
        w_hrdata      = w_s_rdata;
        w_timeout_err = 1'b0;
        case (r_state)
            ST_ERR1: begin
                w_hready      = 1'b0;
                w_hresp       = 1'b1;
                w_hrdata      = '0;
                w_timeout_err = 1'b1;
            end
            ST_ERR2: begin
                w_hready = 1'b1;
                w_hresp  = 1'b1;
                w_hrdata = '0;
            end
            default: ;
        endcase
    end

    assign HREADY      = w_hready;
    assign HRESP       = w_hresp;
    assign HRDATA      = w_hrdata;
    assign TIMEOUT_ERR = w_timeout_err;
    assign ERR_CNT     = r_err_cnt;

    // Consecutive stall counter; any non-stall cycle clears it.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET)      r_cnt <= '0;
        else if (w_stall) r_cnt <= r_cnt + CNT_W'(1);
        else              r_cnt <= '0;
    end

    // Data-phase select advances only when the current transfer completes.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_dsel <= SEL_NONE;
        end else if (w_hready) begin
            if (HTRANS[1]) r_dsel <= w_sel_des ? SEL_DES : SEL_DEF;
            else           r_dsel <= SEL_NONE;
        end
    end

    // Saturating count of completed ERROR responses.
    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            r_err_cnt <= '0;
        end else if (w_hready && w_hresp && (r_err_cnt != {ECNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + ECNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ahb_decode_mux.sv
// Directed self-checking bench for ahb_decode_mux.
module tb_ahb_decode_mux;

    logic        HCLK;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HSEL_DES;
    logic        HSEL_DEF;
    logic        HREADYOUT_DES;
    logic        HRESP_DES;
    logic [63:0] HRDATA_DES;
    logic        HREADYOUT_DEF;
    logic        HRESP_DEF;
    logic [63:0] HRDATA_DEF;
    logic        HREADY;
    logic        HRESP;
    logic [63:0] HRDATA;
    logic        TIMEOUT_ERR;
    logic [7:0]  ERR_CNT;

    int n_pass;
    int n_total;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    ahb_decode_mux dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .HADDR         (HADDR),
        .HTRANS        (HTRANS),
        .HSEL_DES      (HSEL_DES),
        .HSEL_DEF      (HSEL_DEF),
        .HREADYOUT_DES (HREADYOUT_DES),
        .HRESP_DES     (HRESP_DES),
        .HRDATA_DES    (HRDATA_DES),
        .HREADYOUT_DEF (HREADYOUT_DEF),
        .HRESP_DEF     (HRESP_DEF),
        .HRDATA_DEF    (HRDATA_DEF),
        .HREADY        (HREADY),
        .HRESP         (HRESP),
        .HRDATA        (HRDATA),
        .TIMEOUT_ERR   (TIMEOUT_ERR),
        .ERR_CNT       (ERR_CNT)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        HRESET        = 1'b0;
        HADDR         = 32'h0;
        HTRANS        = IDLE;
        HREADYOUT_DES = 1'b1;
        HRESP_DES     = 1'b0;
        HRDATA_DES    = 64'h0;
        HREADYOUT_DEF = 1'b1;
        HRESP_DEF     = 1'b0;
        HRDATA_DEF    = 64'h0;
        #3;
        chk("rst_hready", 64'(HREADY), 64'd1);
        chk("rst_hresp",  64'(HRESP), 64'd0);
        chk("rst_hrdata", HRDATA, 64'd0);
        chk("rst_errcnt", 64'(ERR_CNT), 64'd0);
        chk("rst_tmo",    64'(TIMEOUT_ERR), 64'd0);
        step();
        HRESET = 1'b1;
        step();

        // DES read with zero waits
        HADDR = 32'h8000_0010; HTRANS = NONSEQ; #1;
        chk("dec_des", 64'(HSEL_DES), 64'd1);
        chk("dec_des_def", 64'(HSEL_DEF), 64'd0);
        step();
        // next address phase to the default slave overlaps the DES data phase
        HADDR = 32'h0000_0100; HTRANS = NONSEQ;
        HREADYOUT_DES = 1'b1; HRDATA_DES = 64'hABCD_EF12_3456_7890; #1;
        chk("des_rdata", HRDATA, 64'hABCD_EF12_3456_7890);
        chk("des_hresp", 64'(HRESP), 64'd0);
        chk("des_hready", 64'(HREADY), 64'd1);
        chk("dec_def", 64'(HSEL_DEF), 64'd1);
        chk("dec_def_des", 64'(HSEL_DES), 64'd0);
        step();

        // default slave two-cycle error forwarded unchanged
        HTRANS = IDLE;
        HREADYOUT_DEF = 1'b0; HRESP_DEF = 1'b1; HRDATA_DEF = 64'h1111_2222_3333_4444; #1;
        chk("deferr1_hready", 64'(HREADY), 64'd0);
        chk("deferr1_hresp", 64'(HRESP), 64'd1);
        chk("deferr1_rdata", HRDATA, 64'h1111_2222_3333_4444);
        step();
        HREADYOUT_DEF = 1'b1; HRESP_DEF = 1'b1; #1;
        chk("deferr2_hready", 64'(HREADY), 64'd1);
        chk("deferr2_hresp", 64'(HRESP), 64'd1);
        chk("deferr2_tmo", 64'(TIMEOUT_ERR), 64'd0);
        step();
        HRESP_DEF = 1'b0; #1;
        chk("deferr_cnt", 64'(ERR_CNT), 64'd1);
        chk("idle_hready", 64'(HREADY), 64'd1);

        // DES transfer with 3 waits; dsel must hold while address/trans move
        HADDR = 32'h8000_0040; HTRANS = NONSEQ;
        step();
        HADDR = 32'h8000_0000; HTRANS = IDLE;
        HREADYOUT_DES = 1'b0; HRDATA_DES = 64'h0000_0000_CAFE_0001; #1;
        chk("w1_hready", 64'(HREADY), 64'd0);
        chk("w1_rdata", HRDATA, 64'h0000_0000_CAFE_0001);
        step();
        HADDR = 32'h0000_0100; HTRANS = NONSEQ; #1;
        chk("w2_hready", 64'(HREADY), 64'd0);
        step();
        HADDR = 32'h8000_0000; HTRANS = IDLE; #1;
        chk("w3_hready", 64'(HREADY), 64'd0);
        chk("w3_rdata", HRDATA, 64'h0000_0000_CAFE_0001);
        chk("w3_hresp", 64'(HRESP), 64'd0);
        step();
        HREADYOUT_DES = 1'b1; #1;
        chk("w4_hready", 64'(HREADY), 64'd1);
        step();
        // IDLE data phase: DES outputs must be ignored
        HREADYOUT_DES = 1'b0; HRDATA_DES = 64'hFFFF_0000_FFFF_0000; #1;
        chk("idle_dp_hready", 64'(HREADY), 64'd1);
        chk("idle_dp_hresp", 64'(HRESP), 64'd0);
        chk("idle_dp_rdata", HRDATA, 64'd0);
        chk("idle_dp_errcnt", 64'(ERR_CNT), 64'd1);

        // watchdog abort after 16 stall cycles
        HADDR = 32'h8000_0020; HTRANS = NONSEQ;
        step();
        HTRANS = IDLE; HADDR = 32'h0;
        HREADYOUT_DES = 1'b0; HRESP_DES = 1'b0; HRDATA_DES = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("stall_hready", 64'(HREADY), 64'd0);
            chk("stall_hresp", 64'(HRESP), 64'd0);
            chk("stall_tmo", 64'(TIMEOUT_ERR), 64'd0);
            step();
        end
        #1;
        chk("abort1_hready", 64'(HREADY), 64'd0);
        chk("abort1_hresp", 64'(HRESP), 64'd1);
        chk("abort1_tmo", 64'(TIMEOUT_ERR), 64'd1);
        chk("abort1_rdata", HRDATA, 64'd0);
        step();
        #1;
        chk("abort2_hready", 64'(HREADY), 64'd1);
        chk("abort2_hresp", 64'(HRESP), 64'd1);
        chk("abort2_tmo", 64'(TIMEOUT_ERR), 64'd0);
        chk("abort2_rdata", HRDATA, 64'd0);
        step();
        #1;
        chk("post_abort_cnt", 64'(ERR_CNT), 64'd2);
        chk("post_abort_hready", 64'(HREADY), 64'd1);
        chk("post_abort_hresp", 64'(HRESP), 64'd0);

        // 260 back-to-back default-slave errors: saturate at 8'hFF
        HADDR = 32'h0000_0100; HTRANS = NONSEQ;
        step();
        for (int i = 0; i < 260; i++) begin
            HREADYOUT_DEF = 1'b0; HRESP_DEF = 1'b1;
            step();
            HREADYOUT_DEF = 1'b1; HRESP_DEF = 1'b1;
            if (i == 259) HTRANS = IDLE;
            step();
            chk("sat_cnt", 64'(ERR_CNT), (i + 3 > 255) ? 64'd255 : 64'(i + 3));
        end
        HRESP_DEF = 1'b0;
        step();
        step();
        chk("sat_hold", 64'(ERR_CNT), 64'hFF);

        // async reset mid-stall with DES selected
        HADDR = 32'h8000_0080; HTRANS = NONSEQ;
        step();
        HTRANS = IDLE; HREADYOUT_DES = 1'b0; HRESP_DES = 1'b0; HRDATA_DES = 64'h1234_5678_9ABC_DEF0;
        step();
        step();
        #1;
        chk("pre_rst_hready", 64'(HREADY), 64'd0);
        HRESET = 1'b0; #1;
        chk("arst_hready", 64'(HREADY), 64'd1);
        chk("arst_hresp", 64'(HRESP), 64'd0);
        chk("arst_rdata", HRDATA, 64'd0);
        chk("arst_errcnt", 64'(ERR_CNT), 64'd0);
        chk("arst_tmo", 64'(TIMEOUT_ERR), 64'd0);
        step();
        HRESET = 1'b1;
        HREADYOUT_DES = 1'b1;
        step();
        #1;
        chk("after_rst_hready", 64'(HREADY), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
